my_ip_input: RTL and testbench
==============================

# my_ip_input

Avalon-MM memory-mapped input peripheral for the HPS lightweight bridge: samples WIDTH external switch/button pins, synchronizes and debounces them, latches rising edges into a sticky register, and raises a maskable level interrupt to the HPS. It is the input counterpart of the LED output IP: that block is written by the HPS and drives pins, while this block is driven by pins and read by the HPS. It sits in soc_system beside my_ip_0 on the same clock and reset domain.

## Interface
- WIDTH, 8: number of input pins (1..32).
- DEBOUNCE_CYCLES, 50000: stable cycles required before a level change is accepted (1 ms at 50 MHz); minimum 1.
- clk_clk  input  1  system clock; all logic is on the rising edge.
- reset_reset_n  input  1  asynchronous, active-low reset.
- avs_address  input  2  word address.
- avs_read  input  1  read strobe, single cycle.
- avs_write  input  1  write strobe, single cycle.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data, fixed read latency 1.
- irq  output  1  level interrupt, active high.
- pin_in  input  WIDTH  asynchronous external inputs.

## Operation
- Register map (word addresses):
  - 0 DATA (RO): debounced level, bits [WIDTH-1:0].
  - 1 EDGE (R/W1C): sticky rising-edge flags; writing 1 clears a bit, 0 leaves it.
  - 2 MASK (RW): interrupt enable per bit, bits [WIDTH-1:0].
  - 3 RAW (RO): synchronized, undebounced level.
- Unused upper readdata bits read 0; writes to addresses 0 and 3 are ignored; upper writedata bits are ignored.
- Input path per bit: 2-flop synchronizer (sync1 -> sync2), then debouncer.
- Debouncer per bit: counter of width $clog2(DEBOUNCE_CYCLES+1). If sync2 == debounced, counter <= 0. Otherwise, if counter == DEBOUNCE_CYCLES-1: debounced <= sync2, counter <= 0; else counter <= counter+1. Any bounce back to the debounced value restarts the count.
- Edge detect: EDGE[i] sets when debounced[i] goes 0->1. Falling edges do not set flags.
- Simultaneous set and W1C on the same bit in the same cycle: set wins, so the bit stays 1.
- irq <= |(EDGE & MASK), registered.
- Read and write in the same cycle: readdata returns the pre-write value.
- Reset values: avs_readdata 0, irq 0, EDGE 0, MASK 0, sync flops 0, debounced 0, counters 0.
- Reset mid-operation clears all state immediately, with no pending effects.
- A pin held high through reset release produces a rising edge after debounce; the flag sets, but irq stays 0 because MASK is 0.

## Timing
- Pin change sampled at edge k: sync2 is valid after edge k+1.
- debounced is valid after edge k+1+DEBOUNCE_CYCLES.
- EDGE bit is set after edge k+2+DEBOUNCE_CYCLES.
- irq asserts after edge k+3+DEBOUNCE_CYCLES.
- Read issued at edge n: avs_readdata is valid after edge n and holds until the next read. No waitrequest is used.
- Write takes effect at the edge where avs_write is sampled. irq reflects a MASK or EDGE write one cycle later.

## Configuration
- MY_IP_INPUT_DEBOUNCE_EN defined: debouncer is implemented as above.
- Not defined: counters are removed and debounced <= sync2 every cycle, which is identical to DEBOUNCE_CYCLES=1. DEBOUNCE_CYCLES is ignored. The RAW and DATA registers then differ by one cycle only.

## Test plan
- Reset check: after reset release with pin_in=0, read addresses 0..3 -> 0x0 each; irq=0.
- Debounce, DEBOUNCE_CYCLES=4: pin_in[0] rises at edge k.
  - DATA=0x01 readable after edge k+5.
  - EDGE=0x01 after edge k+6.
  - With MASK=0x01, irq=1 after edge k+7.
- Glitch rejection: pin_in[3] high for 3 cycles, then low (DEBOUNCE_CYCLES=4). DATA stays 0x00, EDGE stays 0x00, RAW shows 0x08 during the pulse.
- W1C and interrupt clear:
  - With EDGE=0x05 and MASK=0xFF, write 0x04 to address 1 -> EDGE=0x01, irq still 1.
  - Write 0x01 -> EDGE=0x00, irq=0 one cycle later.
- Set-wins collision: schedule a W1C of bit 2 in the same cycle that debounced[2] rises -> EDGE[2]=1 afterwards.
- Mask and reset: set MASK=0xA5, trigger an edge on bit 1 -> irq=0. Assert reset_reset_n=0 mid-count -> MASK, EDGE and DATA all read 0 after release.

Source files
------------

// File: rtl/my_ip_input.sv
// my_ip_input: Avalon-MM input peripheral on the HPS lightweight bridge.
//
// Samples WIDTH asynchronous pins. Each pin goes through a two-flop
// synchronizer and a per-bit debouncer. Rising edges of the debounced level
// are latched into sticky EDGE flags, and a registered, maskable level
// interrupt is raised towards the HPS.
//
// Build option: define MY_IP_INPUT_DEBOUNCE_EN to build the counter-based
// debouncer. When it is not defined, the debounced level follows the
// synchronized level one cycle later and DEBOUNCE_CYCLES has no effect.
//
// Register map (word addresses):
//   0 DATA (RO)    debounced level
//   1 EDGE (R/W1C) sticky rising-edge flags
//   2 MASK (RW)    per-bit interrupt enable
//   3 RAW  (RO)    synchronized, undebounced level
//
// Ports:
//   clk_clk        system clock, rising edge
//   reset_reset_n  asynchronous active-low reset
//   avs_address    word address
//   avs_read       read strobe; avs_readdata is valid one cycle later
//   avs_write      write strobe
//   avs_writedata  write data; bits above WIDTH are ignored
//   avs_readdata   read data, zero-extended, held until the next read
//   irq            level interrupt, |(EDGE & MASK), registered
//   pin_in         asynchronous external inputs
module my_ip_input #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] pin_in
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  // Legal range is WIDTH 1..32 and DEBOUNCE_CYCLES >= 1. A bad configuration
  // leaves the marker block g_bad_params in the elaborated hierarchy.
  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
  end

  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^avs_writedata[31:WIDTH];
  end

  logic [WIDTH-1:0] sync_p0;   // first synchronizer flop
  logic [WIDTH-1:0] sync_p1;   // second synchronizer flop (RAW)
  logic [WIDTH-1:0] deb_p2;    // debounced level (DATA)
  logic [WIDTH-1:0] deb_p3;    // debounced level one cycle later
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] rd_mux;

  assign wdata = avs_writedata[WIDTH-1:0];
  assign clr   = (avs_write && avs_address == ADDR_EDGE) ? wdata : '0;
  assign rise  = deb_p2 & ~deb_p3;

  // ---- stage p0/p1: two-flop synchronizer ----
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= pin_in;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: debouncer ----
`ifdef MY_IP_INPUT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [WIDTH];

  // The counter only runs while the synchronized level disagrees with the
  // accepted level; any bounce back restarts it from zero.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      deb_p2 <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb_p2[i] <= sync_p1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      deb_p2 <= '0;
    end else begin
      deb_p2 <= sync_p1;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA: rd_mux = deb_p2;
      ADDR_EDGE: rd_mux = edge_r;
      ADDR_MASK: rd_mux = mask_r;
      ADDR_RAW:  rd_mux = sync_p1;
      default:   rd_mux = '0;
    endcase
  end

  // ---- stage p3: edge flags, mask, interrupt and read port ----
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      deb_p3       <= '0;
      edge_r       <= '0;
      mask_r       <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      deb_p3 <= deb_p2;
      // OR-ing the new rise after the clear lets a set win over a
      // same-cycle write-one-to-clear.
      edge_r <= (edge_r & ~clr) | rise;
      if (avs_write && avs_address == ADDR_MASK) begin
        mask_r <= wdata;
      end
      irq <= |(edge_r & mask_r);
      // rd_mux reflects state before this edge, so a same-cycle write is
      // not visible in the returned data.
      if (avs_read) begin
        avs_readdata <= 32'(rd_mux);
      end
    end
  end

endmodule

// File: tb/tb_my_ip_input.sv
module tb_my_ip_input;

  localparam int W = 8;
`ifdef MY_IP_INPUT_DEBOUNCE_EN
  localparam int DC = 4;
`else
  localparam int DC = 1;
`endif
  localparam int HN = DC + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [W-1:0] pin_in;

  int total;
  int bad;
  logic chk_en;

  always #5 clk = ~clk;

  my_ip_input #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .pin_in        (pin_in)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pin level is accepted once the synchronized samples
  // have disagreed with the accepted level for DC consecutive cycles.
  typedef logic [HN-1:0][W-1:0] hist_t;
  hist_t        m_hist;   // m_hist[0] newest pin sample
  logic [W-1:0] m_deb, m_rose, m_edge, m_mask;
  logic         m_irq;
  logic [31:0]  m_rd;

  function automatic logic [W-1:0] settle(input hist_t h, input logic [W-1:0] d);
    logic [W-1:0] r;
    logic held;
    r = d;
    for (int b = 0; b < W; b++) begin
      held = 1'b1;
      for (int j = 1; j <= DC; j++) begin
        if (h[j][b] == d[b]) held = 1'b0;
      end
      if (held) r[b] = ~d[b];
    end
    return r;
  endfunction

  function automatic logic [31:0] view(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_deb);
      2'd1:    return 32'(m_edge);
      2'd2:    return 32'(m_mask);
      default: return 32'(m_hist[1]);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist <= '0;
      m_deb  <= '0;
      m_rose <= '0;
      m_edge <= '0;
      m_mask <= '0;
      m_irq  <= 1'b0;
      m_rd   <= '0;
    end else begin
      m_hist <= {m_hist[HN-2:0], pin_in};
      m_deb  <= settle(m_hist, m_deb);
      m_rose <= settle(m_hist, m_deb) & ~m_deb;
      m_edge <= (m_edge & ~((avs_write && avs_address == 2'd1) ? avs_writedata[W-1:0] : '0)) | m_rose;
      if (avs_write && avs_address == 2'd2) m_mask <= avs_writedata[W-1:0];
      m_irq <= |(m_edge & m_mask);
      if (avs_read) m_rd <= view(avs_address);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rdata", avs_readdata, m_rd);
      check("model_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d = avs_readdata;
  endtask

  task automatic bus_rw(input logic [1:0] a, input logic [31:0] wd, output logic [31:0] d);
    avs_address   = a;
    avs_writedata = wd;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    d = avs_readdata;
  endtask

  task automatic do_reset(input logic [W-1:0] p);
    pin_in = p;
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int hold;

    vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 2'd2, 32'hFFFF_FFA5, 32'h0};
    vecs[5]  = '{1'b0, 2'd2, 32'h0,         32'h0000_00A5};
    vecs[6]  = '{1'b1, 2'd0, 32'h0000_00FF, 32'h0};
    vecs[7]  = '{1'b0, 2'd0, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 2'd3, 32'h0000_00FF, 32'h0};
    vecs[9]  = '{1'b0, 2'd3, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 2'd1, 32'h0000_00FF, 32'h0};
    vecs[11] = '{1'b0, 2'd1, 32'h0,         32'h0};
    vecs[12] = '{1'b1, 2'd2, 32'h0000_003C, 32'h0};
    vecs[13] = '{1'b0, 2'd2, 32'h0,         32'h0000_003C};
    vecs[14] = '{1'b1, 2'd2, 32'h0,         32'h0};
    vecs[15] = '{1'b0, 2'd2, 32'h0,         32'h0};

    total = 0;
    bad = 0;
    chk_en = 1'b0;
    rst_n = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    pin_in = '0;
    hold = 0;

    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Reset state and register access table
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_rdata", avs_readdata, 32'h0);
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end

    // Read and write in the same cycle returns the old value
    bus_write(2'd2, 32'h3C);
    bus_rw(2'd2, 32'h11, rd);
    check("rw_same_cycle_old", rd, 32'h3C);
    bus_read(2'd2, rd);
    check("rw_same_cycle_new", rd, 32'h11);

    // Debounce latency: pin[0] sampled at edge k
    do_reset('0);
    bus_write(2'd2, 32'h01);
    pin_in = 8'h01;
    repeat (DC + 1) @(negedge clk);
    bus_read(2'd0, rd);
    check("deb_data_early", rd, 32'h00);
    bus_read(2'd0, rd);
    check("deb_data_valid", rd, 32'h01);
    check("deb_irq_early", {31'b0, irq}, 32'h0);
    bus_read(2'd1, rd);
    check("deb_edge_valid", rd, 32'h01);
    check("deb_irq_valid", {31'b0, irq}, 32'h1);

    // Short pulse on pin[3]
    do_reset('0);
`ifdef MY_IP_INPUT_DEBOUNCE_EN
    pin_in = 8'h08;
    @(negedge clk);
    @(negedge clk);
    bus_read(2'd3, rd);
    check("glitch_raw", rd, 32'h08);
    pin_in = 8'h00;
    repeat (DC + 4) @(negedge clk);
    bus_read(2'd0, rd);
    check("glitch_data", rd, 32'h00);
    bus_read(2'd1, rd);
    check("glitch_edge", rd, 32'h00);
`else
    pin_in = 8'h08;
    @(negedge clk);
    pin_in = 8'h00;
    @(negedge clk);
    bus_read(2'd3, rd);
    check("pulse_raw", rd, 32'h08);
    repeat (4) @(negedge clk);
    bus_read(2'd0, rd);
    check("pulse_data", rd, 32'h00);
    bus_read(2'd1, rd);
    check("pulse_edge", rd, 32'h08);
`endif

    // W1C and interrupt clear
    do_reset('0);
    bus_write(2'd2, 32'hFF);
    pin_in = 8'h05;
    repeat (DC + 6) @(negedge clk);
    bus_read(2'd1, rd);
    check("w1c_edge_init", rd, 32'h05);
    check("w1c_irq_init", {31'b0, irq}, 32'h1);
    bus_write(2'd1, 32'h04);
    check("w1c_irq_after_partial", {31'b0, irq}, 32'h1);
    bus_read(2'd1, rd);
    check("w1c_edge_partial", rd, 32'h01);
    check("w1c_irq_still", {31'b0, irq}, 32'h1);
    bus_write(2'd1, 32'h01);
    check("w1c_irq_lag", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("w1c_irq_cleared", {31'b0, irq}, 32'h0);
    bus_read(2'd1, rd);
    check("w1c_edge_cleared", rd, 32'h00);

    // Set wins over a same-cycle W1C
    do_reset('0);
    pin_in = 8'h04;
    repeat (DC + 2) @(negedge clk);
    bus_write(2'd1, 32'h04);
    bus_read(2'd1, rd);
    check("collide_set_wins", rd, 32'h04);
    bus_write(2'd1, 32'h04);
    bus_read(2'd1, rd);
    check("collide_later_clear", rd, 32'h00);

    // Mask gating and reset in mid count
    do_reset('0);
    bus_write(2'd2, 32'hA5);
    pin_in = 8'h02;
    repeat (DC + 6) @(negedge clk);
    check("mask_irq_blocked", {31'b0, irq}, 32'h0);
    bus_read(2'd1, rd);
    check("mask_edge", rd, 32'h02);
    bus_read(2'd2, rd);
    check("mask_value", rd, 32'hA5);
    pin_in = 8'h12;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_async_rdata", avs_readdata, 32'h0);
    check("rst_async_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    bus_read(2'd0, rd);
    check("rst_data", rd, 32'h00);
    bus_read(2'd2, rd);
    check("rst_mask", rd, 32'h00);
    bus_read(2'd1, rd);
    check("rst_edge", rd, 32'h00);
    repeat (DC + 6) @(negedge clk);
    bus_read(2'd1, rd);
    check("held_pin_edge", rd, 32'h12);
    check("held_pin_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd0, rd);
    check("held_pin_data", rd, 32'h12);

    // Randomized traffic against the reference model
    do_reset('0);
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        pin_in = W'($urandom);
        hold = $urandom_range(0, 2 * DC + 4);
      end else begin
        hold--;
      end
      avs_address   = 2'($urandom_range(0, 3));
      avs_read      = ($urandom_range(0, 1) == 1);
      avs_write     = ($urandom_range(0, 3) == 0);
      avs_writedata = $urandom;
      if (c == 1000) begin
        avs_read  = 1'b0;
        avs_write = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    avs_read  = 1'b0;
    avs_write = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
